// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Serves MULT/MULTU/DIV/DIVU/MTHI/MTLO beside the execute-stage ALU.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_NOP6  = 3'd6,
    OP_NOP7  = 3'd7
  } op_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt;
  logic                 is_div, neg_res, neg_rem, div_zero;
  logic [WIDTH-1:0]     mag;   // multiplicand (MULT) or divisor (DIV) magnitude
  logic [2*WIDTH-1:0]   acc;   // {partial product | remainder, multiplier | quotient}

  op_t                  op_e;
  logic                 start_md, start_mt, fix_commit;
  logic                 signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]     abs_a, abs_b;

  logic [WIDTH:0]       mul_sum, add_val;
  logic [WIDTH:0]       shifted, rem_full;
  logic                 div_ok;
  logic [2*WIDTH-1:0]   mul_next, div_next, step;
  logic                 unused_rem_msb;

  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quot, rem, res_hi, res_lo;

  assign op_e = op_t'(op);

  // Decode and next-state logic.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_n    = state;
    start_md   = 1'b0;
    start_mt   = 1'b0;
    fix_commit = 1'b0;
    signed_op  = (op_e == OP_MULT) || (op_e == OP_DIV);
    a_neg      = signed_op && opA[WIDTH-1];
    b_neg      = signed_op && opB[WIDTH-1];
    abs_a      = a_neg ? -opA : opA;
    abs_b      = b_neg ? -opB : opB;

    unique case (state)
      IDLE: begin
        // abort outranks start even though nothing is in flight
        if (start && !abort) begin
          start_md = (op_e == OP_MULT) || (op_e == OP_MULTU) ||
                     (op_e == OP_DIV)  || (op_e == OP_DIVU);
          start_mt = (op_e == OP_MTHI) || (op_e == OP_MTLO);
        end
        if (start_md) state_n = RUN;
      end
      RUN: begin
        if (abort)                     state_n = IDLE;
        else if (cnt == CNT_W'(1))     state_n = FIX;
      end
      FIX: begin
        fix_commit = !abort;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // One radix-2 iteration of either datapath.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag};
    add_val  = acc[0] ? mul_sum : {1'b0, acc[2*WIDTH-1:WIDTH]};
    mul_next = {add_val, acc[WIDTH-1:1]};

    shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ok   = (shifted >= {1'b0, mag});
    rem_full = div_ok ? (shifted - {1'b0, mag}) : shifted;
    div_next = {rem_full[WIDTH-1:0], acc[WIDTH-2:0], div_ok};

    step     = is_div ? div_next : mul_next;
  end

  // Remainder is always below the divisor, so the top bit is provably zero.
  assign unused_rem_msb = rem_full[WIDTH];

  // Sign fix-up applied in FIX. Divide-by-zero falls out of the restoring
  // loop as remainder = |dividend|, so only the quotient needs forcing.
  always_comb begin
    prod   = neg_res ? -acc : acc;
    quot   = acc[WIDTH-1:0];
    rem    = acc[2*WIDTH-1:WIDTH];
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div) begin
      res_hi = neg_rem ? -rem : rem;
      res_lo = div_zero ? '1 : (neg_res ? -quot : quot);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      mag      <= '0;
      acc      <= '0;
    end else begin
      state <= state_n;
      busy  <= (state_n != IDLE);
      done  <= fix_commit || start_mt;

      if (start_md) begin
        cnt      <= CNT_W'(WIDTH);
        is_div   <= op[1];
        neg_res  <= a_neg ^ b_neg;
        neg_rem  <= a_neg;
        div_zero <= (opB == '0);
        mag      <= op[1] ? abs_b : abs_a;
        acc      <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
      end else if (state == RUN && !abort) begin
        cnt <= cnt - CNT_W'(1);
        acc <= step;
      end

      if (fix_commit) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (start_mt) begin
        if (op_e == OP_MTHI) hi <= opA;
        else                 lo <= opA;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: a 32-bit and an 8-bit instance share
// operands; expected HI/LO come from a behavioural model at issue time.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        start = 1'b0, start8 = 1'b0, abort = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] opA = '0, opB = '0;
  logic        busy, done, busy8, done8;
  logic [31:0] hi, lo;
  logic [7:0]  hi8, lo8;

  int errors = 0;
  int checks = 0;

  logic [63:0] q32[$];
  logic [63:0] q8[$];
  logic [63:0] m32 = '0;  // model {hi,lo}
  logic [63:0] m8  = '0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .resetN(resetN), .start(start), .op(op), .opA(opA), .opB(opB),
    .abort(abort), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  mul_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .resetN(resetN), .start(start8), .op(op), .opA(opA[7:0]), .opB(opB[7:0]),
    .abort(abort), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Architectural HI/LO after op o, given the current {hi,lo}; w-bit operands.
  function automatic logic [63:0] model(input int w, input logic [2:0] o,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [63:0] cur);
    logic [63:0] mask, ua, ub, p;
    longint      sa, sb, q, r;
    logic [31:0] rh, rl;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'd0, a} & mask;
    ub   = {32'd0, b} & mask;
    sa   = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
    sb   = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
    rh   = cur[63:32];
    rl   = cur[31:0];
    case (o)
      3'd0: begin p = 64'(sa * sb); rh = 32'((p >> w) & mask); rl = 32'(p & mask); end
      3'd1: begin p = ua * ub;      rh = 32'((p >> w) & mask); rl = 32'(p & mask); end
      3'd2: begin
        if (ub == 0) begin rh = 32'(ua); rl = 32'(mask); end
        else if (ua == (64'd1 << (w-1)) && ub == mask) begin rh = 32'd0; rl = 32'(ua); end
        else begin
          q = sa / sb; r = sa % sb;
          rl = 32'(64'(q) & mask); rh = 32'(64'(r) & mask);
        end
      end
      3'd3: begin
        if (ub == 0) begin rh = 32'(ua); rl = 32'(mask); end
        else begin rl = 32'(ua / ub); rh = 32'(ua % ub); end
      end
      3'd4: rh = 32'(ua);
      3'd5: rl = 32'(ua);
      default: ;
    endcase
    return {rh, rl};
  endfunction

  // Scoreboard monitors: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (resetN && done) begin
      if (q32.size() == 0) check("unexpected_done32", 64'(done), 64'd0);
      else begin
        logic [63:0] e;
        e = q32.pop_front();
        check("hi32", 64'(hi), 64'(e[63:32]));
        check("lo32", 64'(lo), 64'(e[31:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (resetN && done8) begin
      if (q8.size() == 0) check("unexpected_done8", 64'(done8), 64'd0);
      else begin
        logic [63:0] e;
        e = q8.pop_front();
        check("hi8", 64'(hi8), 64'(e[63:32]));
        check("lo8", 64'(lo8), 64'(e[31:0]));
      end
    end
  end

  // Called at a negedge; returns at the next negedge with start released.
  task automatic issue(input int w, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input bit push);
    op = o; opA = a; opB = b;
    if (w == 8) start8 = 1'b1; else start = 1'b1;
    if (push && o < 3'd6) begin
      if (w == 8) begin m8 = model(8, o, a, b, m8); q8.push_back(m8); end
      else begin m32 = model(32, o, a, b, m32); q32.push_back(m32); end
    end
    @(negedge clk);
    start = 1'b0; start8 = 1'b0;
    opA = $urandom; opB = $urandom;
  endtask

  // Counts busy cycles until done (bounded); optionally pokes an MTHI start mid-flight.
  task automatic wait_result(input int w, input int exp_busy, input bit exp_done, input int inject);
    int bc;
    bit got;
    bc = 0; got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (i == inject) begin
        op = 3'd4; opA = 32'h5555_5555;
        if (w == 8) start8 = 1'b1; else start = 1'b1;
      end
      if (i == inject + 1) begin start = 1'b0; start8 = 1'b0; end
      if ((w == 8) ? busy8 : busy) bc++;
      if ((w == 8) ? done8 : done) got = 1'b1;
      else @(negedge clk);
    end
    start = 1'b0; start8 = 1'b0;
    check("done_seen", 64'(got), 64'(exp_done));
    check("busy_cycles", 64'(bc), 64'(exp_busy));
  endtask

  task automatic run_op(input int w, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int inject);
    issue(w, o, a, b, 1'b1);
    wait_result(w, (o < 3'd4) ? w + 1 : 0, o < 3'd6, inject);
    @(negedge clk);
    check("done_pulse", 64'((w == 8) ? done8 : done), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    resetN = 1'b1;
    @(negedge clk);

    // Load HI/LO, then reset asynchronously in the middle of a DIV.
    run_op(32, 3'd5, 32'h1234_5678, 32'd0, -1);
    run_op(32, 3'd4, 32'h9abc_def0, 32'd0, -1);
    issue(32, 3'd2, 32'd1000, 32'd7, 1'b0);
    repeat (5) @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_hi", 64'(hi), 64'd0);
    check("async_rst_lo", 64'(lo), 64'd0);
    m32 = '0;
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);

    run_op(32, 3'd4, 32'hdead_beef, 32'd0, -1);
    run_op(32, 3'd1, 32'hffff_ffff, 32'hffff_ffff, -1);
    run_op(32, 3'd0, -32'sd3, 32'd7, 4);           // start while busy must be ignored
    run_op(32, 3'd2, -32'sd7, 32'd2, -1);
    run_op(32, 3'd2, 32'h8000_0000, 32'hffff_ffff, -1);
    run_op(32, 3'd3, 32'd100, 32'd0, -1);
    run_op(32, 3'd2, -32'sd9, 32'd0, -1);

    // Abort in RUN (cycle 10) and in FIX: no done, HI/LO untouched.
    issue(32, 3'd3, 32'd100, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    wait_result(32, 0, 1'b0, -1);
    check("abort_hi", 64'(hi), 64'(m32[63:32]));
    check("abort_lo", 64'(lo), 64'(m32[31:0]));

    issue(32, 3'd1, 32'd11, 32'd13, 1'b0);
    repeat (32) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_result(32, 0, 1'b0, -1);
    check("abort_fix_lo", 64'(lo), 64'(m32[31:0]));

    // abort beats start in IDLE; no-op codes do nothing.
    abort = 1'b1; start = 1'b1; op = 3'd4; opA = 32'h7777_7777;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    wait_result(32, 0, 1'b0, -1);
    check("abort_start_hi", 64'(hi), 64'(m32[63:32]));
    run_op(32, 3'd6, 32'h1111_1111, 32'd2, -1);
    run_op(32, 3'd7, 32'h2222_2222, 32'd3, -1);

    // Back-to-back: MULTU issued in the MTLO done cycle.
    issue(32, 3'd5, 32'h0000_0099, 32'd0, 1'b1);
    wait_result(32, 0, 1'b1, -1);
    issue(32, 3'd1, 32'd6, 32'd7, 1'b1);
    wait_result(32, 33, 1'b1, -1);
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)) * ((i % 3 == 0) ? -1 : 1);
      run_op(32, 3'($urandom_range(0, 3)), a, b, -1);
    end

    // Narrow instance.
    run_op(8, 3'd0, 32'h80, 32'h80, -1);
    run_op(8, 3'd3, 32'd200, 32'd9, -1);
    run_op(8, 3'd2, 32'h80, 32'hff, -1);
    run_op(8, 3'd2, 32'hf9, 32'h02, -1);
    run_op(8, 3'd3, 32'd77, 32'd0, -1);
    for (int i = 0; i < 4; i++)
      run_op(8, 3'($urandom_range(0, 3)), $urandom, $urandom, -1);

    check("q32_drained", 64'(q32.size()), 64'd0);
    check("q8_drained", 64'(q8.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
